// File: rtl/control_sequencer.sv
// Purpose : multi-cycle RV32 control FSM; fetch, dispatch, execute, debug halt/resume/step.
// Latency : strobes decode combinationally from the current state; one state per clock.
// Backpr. : memory stalls hold PROLOGUE/LOAD_W/STORE_W until i_mem_complete or the bus timeout.
// Ports   : i_clk, i_rst (sync, active-high); i_opcode = IR[6:2]; i_mem_complete; debug
//           i_halt_req (level), i_resume_req (pulse), i_step. Outputs: datapath strobes
//           o_write_pc/ir/rd, o_mem_read/write, selects o_addr_sel, o_rd_sel, o_alu_insel1/2,
//           debug status o_halted, o_cause, and o_state (raw state code).
module control_sequencer #(
  parameter int MEM_TIMEOUT   = 16,
  parameter int HALT_ON_RESET = 0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [4:0] i_opcode,
  input  logic       i_mem_complete,
  input  logic       i_halt_req,
  input  logic       i_resume_req,
  input  logic       i_step,
  output logic       o_write_pc,
  output logic       o_write_ir,
  output logic       o_write_rd,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_addr_sel,
  output logic [1:0] o_rd_sel,
  output logic [1:0] o_alu_insel1,
  output logic [1:0] o_alu_insel2,
  output logic       o_halted,
  output logic [2:0] o_cause,
  output logic [4:0] o_state
);

  // Execute states reuse the opcode value, so DISPATCH can jump straight to i_opcode.
  localparam logic [4:0] S_PROLOGUE = 5'b10000;
  localparam logic [4:0] S_DISPATCH = 5'b10001;
  localparam logic [4:0] S_HALTED   = 5'b10010;
  localparam logic [4:0] S_LUI      = 5'b01101;
  localparam logic [4:0] S_AUIPC    = 5'b00101;
  localparam logic [4:0] S_JAL      = 5'b11011;
  localparam logic [4:0] S_JALR     = 5'b11001;
  localparam logic [4:0] S_BRANCH   = 5'b11000;
  localparam logic [4:0] S_LOAD     = 5'b00000;
  localparam logic [4:0] S_LOAD_W   = 5'b00001;
  localparam logic [4:0] S_LOAD_1   = 5'b00010;
  localparam logic [4:0] S_STORE    = 5'b01000;
  localparam logic [4:0] S_STORE_W  = 5'b01001;
  localparam logic [4:0] S_STORE_1  = 5'b01010;
  localparam logic [4:0] S_OPIMM    = 5'b00100;
  localparam logic [4:0] S_OP       = 5'b01100;
  localparam logic [4:0] S_MISCMEM  = 5'b00011;
  localparam logic [4:0] S_SYSTEM   = 5'b11100;

  localparam logic [2:0] C_NONE    = 3'd0;
  localparam logic [2:0] C_HALT    = 3'd1;
  localparam logic [2:0] C_EBREAK  = 3'd2;
  localparam logic [2:0] C_ILLEGAL = 3'd3;
  localparam logic [2:0] C_BUS     = 3'd4;
  localparam logic [2:0] C_STEP    = 3'd5;

  localparam int            CW  = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMO = CW'(MEM_TIMEOUT);

  logic [4:0]    r_state, w_nxt_state;
  logic [2:0]    r_cause, w_nxt_cause;
  logic          r_step_arm, w_nxt_step_arm;
  logic [CW-1:0] r_cnt, w_nxt_cnt;
  logic          w_waiting, w_timeout, w_legal;

  assign w_waiting = (r_state == S_PROLOGUE) || (r_state == S_LOAD_W) || (r_state == S_STORE_W);
  // A completion arriving in the expiry cycle takes priority over the fault.
  assign w_timeout = (MEM_TIMEOUT != 0) && w_waiting && !i_mem_complete && (r_cnt == TMO);

  always_comb begin
    case (i_opcode)
      S_LUI, S_AUIPC, S_JAL, S_JALR, S_BRANCH, S_LOAD,
      S_STORE, S_OPIMM, S_OP, S_MISCMEM, S_SYSTEM: w_legal = 1'b1;
      default:                                     w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_cause    = r_cause;
    w_nxt_step_arm = r_step_arm;
    case (r_state)
      S_PROLOGUE: begin
        if (i_mem_complete) begin
          w_nxt_state = S_DISPATCH;
        end else if (w_timeout) begin
          w_nxt_state = S_HALTED;
          w_nxt_cause = C_BUS;
        end
      end
      S_DISPATCH: begin
        if (w_legal) begin
          w_nxt_state = i_opcode;
        end else begin
          w_nxt_state = S_HALTED;
          w_nxt_cause = C_ILLEGAL;
        end
      end
      S_LOAD:  w_nxt_state = S_LOAD_W;
      S_STORE: w_nxt_state = S_STORE_W;
      S_LOAD_W, S_STORE_W: begin
        // Halt requests are deliberately ignored here: an access is never abandoned.
        if (i_mem_complete) begin
          w_nxt_state = (r_state == S_LOAD_W) ? S_LOAD_1 : S_STORE_1;
        end else if (w_timeout) begin
          w_nxt_state = S_HALTED;
          w_nxt_cause = C_BUS;
        end
      end
      S_SYSTEM: begin
        w_nxt_state = S_HALTED;
        w_nxt_cause = C_EBREAK;
      end
      S_HALTED: begin
        if (i_resume_req) begin
          w_nxt_state    = S_PROLOGUE;
          w_nxt_cause    = C_NONE;
          w_nxt_step_arm = i_step;
        end
      end
      S_LUI, S_AUIPC, S_JAL, S_JALR, S_BRANCH, S_OPIMM,
      S_OP, S_MISCMEM, S_LOAD_1, S_STORE_1: begin
        // Instruction boundary: the only place debug halts are taken.
        if (i_halt_req) begin
          w_nxt_state = S_HALTED;
          w_nxt_cause = C_HALT;
        end else if (r_step_arm) begin
          w_nxt_state = S_HALTED;
          w_nxt_cause = C_STEP;
        end else begin
          w_nxt_state = S_PROLOGUE;
        end
      end
      default: w_nxt_state = S_PROLOGUE;
    endcase
  end

  // Counter runs only while parked in a wait state; any transition clears it, so
  // every fresh entry into a wait state starts from zero.
  always_comb begin
    w_nxt_cnt = '0;
    if ((MEM_TIMEOUT != 0) && w_waiting && (w_nxt_state == r_state)) begin
      w_nxt_cnt = r_cnt + CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= (HALT_ON_RESET != 0) ? S_HALTED : S_PROLOGUE;
      r_cause    <= C_NONE;
      r_step_arm <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_nxt_state;
      r_cause    <= w_nxt_cause;
      r_step_arm <= w_nxt_step_arm;
      r_cnt      <= w_nxt_cnt;
    end
  end

  always_comb begin
    o_write_pc   = 1'b0;
    o_write_ir   = 1'b0;
    o_write_rd   = 1'b0;
    o_mem_read   = 1'b0;
    o_mem_write  = 1'b0;
    o_addr_sel   = 1'b0;
    o_rd_sel     = 2'b00;
    o_alu_insel1 = 2'b00;
    o_alu_insel2 = 2'b00;
    case (r_state)
      S_PROLOGUE: begin
        o_addr_sel = 1'b1;
        o_mem_read = !w_timeout;
        o_write_ir = i_mem_complete;
      end
      S_LUI:     begin o_alu_insel1 = 2'b10; o_alu_insel2 = 2'b01; o_write_rd = 1'b1; o_write_pc = 1'b1; end
      S_AUIPC:   begin o_alu_insel1 = 2'b01; o_alu_insel2 = 2'b01; o_write_rd = 1'b1; o_write_pc = 1'b1; end
      S_JAL: begin
        o_alu_insel1 = 2'b01; o_alu_insel2 = 2'b01; o_rd_sel = 2'b10;
        o_write_rd   = 1'b1;  o_write_pc   = 1'b1;
      end
      S_JALR: begin
        o_alu_insel2 = 2'b01; o_rd_sel = 2'b10; o_write_rd = 1'b1; o_write_pc = 1'b1;
      end
      S_BRANCH:  o_write_pc = 1'b1;
      S_OPIMM:   begin o_alu_insel2 = 2'b01; o_write_rd = 1'b1; o_write_pc = 1'b1; end
      S_OP:      begin o_write_rd = 1'b1; o_write_pc = 1'b1; end
      S_MISCMEM: o_write_pc = 1'b1;
      S_LOAD, S_LOAD_W: begin
        o_alu_insel2 = 2'b01;
        o_mem_read   = !w_timeout;
      end
      S_LOAD_1:  begin o_rd_sel = 2'b01; o_write_rd = 1'b1; o_write_pc = 1'b1; end
      S_STORE, S_STORE_W: begin
        o_alu_insel2 = 2'b10;
        o_mem_write  = !w_timeout;
      end
      S_STORE_1: o_write_pc = 1'b1;
      default: ;
    endcase
  end

  assign o_halted = (r_state == S_HALTED);
  assign o_cause  = r_cause;
  assign o_state  = r_state;

endmodule
